// File: rtl/gpio_responder.sv
// rtl/gpio_responder.sv - memory-mapped GPIO block with synchronized inputs, change detection and interrupt
// Two GPIO input ports are synchronized and edge-watched; two output ports are CPU-written registers.
module gpio_responder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [4:0]       a,
  input  logic [WIDTH-1:0] wd,
  output logic [WIDTH-1:0] rd,
  input  logic [WIDTH-1:0] gpI1,
  input  logic [WIDTH-1:0] gpI2,
  output logic [WIDTH-1:0] gpO1,
  output logic [WIDTH-1:0] gpO2,
  output logic             irq
);

  localparam logic [2:0] W_IN1    = 3'd0;
  localparam logic [2:0] W_IN2    = 3'd1;
  localparam logic [2:0] W_OUT1   = 3'd2;
  localparam logic [2:0] W_OUT2   = 3'd3;
  localparam logic [2:0] W_STATUS = 3'd4;
  localparam logic [2:0] W_CTRL   = 3'd5;

  logic [WIDTH-1:0] sync1_1, sync2_1, prev_1;
  logic [WIDTH-1:0] sync1_2, sync2_2, prev_2;
  logic [WIDTH-1:0] out1, out2;
  logic [1:0]       status, ctrl;
  logic [1:0]       prime;

  logic [2:0]       word;
  logic             wr_out1, wr_out2, wr_status, wr_ctrl;
  logic             primed;
  logic [1:0]       change, clear, status_next;
  logic             unused_a;

  assign word     = a[4:2];
  assign unused_a = ^a[1:0];

  always_comb begin
    wr_out1     = we && (word == W_OUT1);
    wr_out2     = we && (word == W_OUT2);
    wr_status   = we && (word == W_STATUS);
    wr_ctrl     = we && (word == W_CTRL);
    primed      = (prime == 2'd3);
    change      = 2'b00;
    if (primed) begin
      change[0] = (sync2_1 != prev_1);
      change[1] = (sync2_2 != prev_2);
    end
    clear       = wr_status ? wd[1:0] : 2'b00;
    // A change detected in the same cycle as a W1C store wins.
    status_next = (status & ~clear) | change;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_1 <= '0;
      sync2_1 <= '0;
      prev_1  <= '0;
      sync1_2 <= '0;
      sync2_2 <= '0;
      prev_2  <= '0;
      prime   <= 2'd0;
    end else begin
      sync1_1 <= gpI1;
      sync2_1 <= sync1_1;
      prev_1  <= sync2_1;
      sync1_2 <= gpI2;
      sync2_2 <= sync1_2;
      prev_2  <= sync2_2;
      if (!primed) begin
        prime <= prime + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out1   <= '0;
      out2   <= '0;
      status <= 2'b00;
      ctrl   <= 2'b00;
    end else begin
      if (wr_out1) begin
        out1 <= wd;
      end
      if (wr_out2) begin
        out2 <= wd;
      end
      if (wr_ctrl) begin
        ctrl <= wd[1:0];
      end
      status <= status_next;
    end
  end

  assign gpO1 = out1;
  assign gpO2 = out2;
  assign irq  = |(status & ctrl);

  // Loads are pure reads of register state; every register clears in reset so rd reads 0 there.
  always_comb begin
    rd = '0;
    case (word)
      W_IN1:    rd = sync2_1;
      W_IN2:    rd = sync2_2;
      W_OUT1:   rd = out1;
      W_OUT2:   rd = out2;
      W_STATUS: rd = {{(WIDTH-2){1'b0}}, status};
      W_CTRL:   rd = {{(WIDTH-2){1'b0}}, ctrl};
      default:  rd = '0;
    endcase
  end

endmodule

// File: tb/tb_gpio_responder.sv
// tb/tb_gpio_responder.sv - directed scenarios plus randomized traffic against a history-based model
module tb_gpio_responder;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         we = 1'b0;
  logic [4:0]   a = '0;
  logic [W-1:0] wd = '0;
  logic [W-1:0] rd;
  logic [W-1:0] gpI1 = '0;
  logic [W-1:0] gpI2 = '0;
  logic [W-1:0] gpO1, gpO2;
  logic         irq;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  gpio_responder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .we(we), .a(a), .wd(wd), .rd(rd),
    .gpI1(gpI1), .gpI2(gpI2), .gpO1(gpO1), .gpO2(gpO2), .irq(irq)
  );

  // Model: inputs sampled at every edge since reset release, indexed by edge number.
  int           n;
  logic [W-1:0] h1 [0:4095];
  logic [W-1:0] h2 [0:4095];
  logic [W-1:0] m_out1, m_out2;
  logic [1:0]   m_status, m_ctrl;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    n = 0;
    m_out1 = '0;
    m_out2 = '0;
    m_status = 2'b00;
    m_ctrl = 2'b00;
  endtask

  task automatic model_edge();
    logic [1:0] set, clr;
    if (!rst) return;
    n = n + 1;
    h1[n] = gpI1;
    h2[n] = gpI2;
    set = 2'b00;
    // Synchronizer fill takes three edges; only from the fourth edge is a history difference reported.
    if (n >= 4) begin
      set[0] = (h1[n-2] != h1[n-3]);
      set[1] = (h2[n-2] != h2[n-3]);
    end
    clr = 2'b00;
    if (we) begin
      case (a / 4)
        2: m_out1 = wd;
        3: m_out2 = wd;
        4: clr = wd[1:0];
        5: m_ctrl = wd[1:0];
        default: ;
      endcase
    end
    m_status = (m_status & ~clr) | set;
  endtask

  function automatic logic [W-1:0] exp_rd(input logic [4:0] addr);
    case (addr / 4)
      0: return (n >= 2) ? h1[n-1] : '0;
      1: return (n >= 2) ? h2[n-1] : '0;
      2: return m_out1;
      3: return m_out2;
      4: return W'(m_status);
      5: return W'(m_ctrl);
      default: return '0;
    endcase
  endfunction

  function automatic logic exp_irq();
    return |(m_status & m_ctrl);
  endfunction

  initial forever begin
    @(posedge clk);
    model_edge();
  end

  task automatic cycle(input logic w, input logic [4:0] ad, input logic [W-1:0] d);
    @(negedge clk);
    check_eq("gpO1", gpO1, m_out1);
    check_eq("gpO2", gpO2, m_out2);
    check_eq("irq", W'(irq), W'(exp_irq()));
    we = w;
    a = ad;
    wd = d;
    #1;
    check_eq($sformatf("rd@%02h", ad), rd, exp_rd(ad));
  endtask

  task automatic do_reset(input int hold);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_eq("rst_gpO1", gpO1, '0);
    check_eq("rst_gpO2", gpO2, '0);
    check_eq("rst_irq", W'(irq), '0);
    for (int i = 0; i < 8; i++) begin
      a = 5'(i * 4);
      #1;
      check_eq($sformatf("rst_rd@%02h", i * 4), rd, '0);
    end
    we = 1'b1;
    a = 5'h08;
    wd = $urandom | 32'h1;
    repeat (hold) @(posedge clk);
    #1;
    check_eq("rst_store_gpO1", gpO1, '0);
    @(negedge clk);
    #2;
    we = 1'b0;
    rst = 1'b1;
  endtask

  initial begin
    model_reset();
    gpI1 = 32'd5;
    gpI2 = 32'd5;
    #1;
    check_eq("init_irq", W'(irq), '0);
    check_eq("init_rd00", rd, '0);
    #11 rst = 1'b1;

    // Reset priming
    cycle(0, 5'h00, '0);
    cycle(0, 5'h00, '0);
    check_eq("prime_in1", rd, 32'd5);
    cycle(0, 5'h04, '0);
    check_eq("prime_in2", rd, 32'd5);
    repeat (4) cycle(0, 5'h10, '0);
    check_eq("prime_status", rd, '0);

    // Output store
    cycle(1, 5'h0C, 32'd120);
    cycle(0, 5'h0C, '0);
    check_eq("out2_rd", rd, 32'd120);
    check_eq("out2_pin", gpO2, 32'd120);
    check_eq("out1_pin", gpO1, '0);

    // Change and interrupt
    cycle(1, 5'h14, 32'h1);
    gpI1 = 32'd7;
    repeat (3) cycle(0, 5'h10, '0);
    check_eq("chg_status", rd, 32'h1);
    check_eq("chg_irq", W'(irq), 32'h1);
    cycle(0, 5'h00, '0);
    check_eq("chg_in1", rd, 32'd7);

    // W1C racing a fresh detection
    gpI1 = 32'd3;
    cycle(0, 5'h10, '0);
    cycle(1, 5'h10, 32'h1);
    cycle(0, 5'h10, '0);
    check_eq("race_status", rd, 32'h1);

    // W1C then masked input change
    cycle(1, 5'h10, 32'h3);
    cycle(0, 5'h10, '0);
    check_eq("w1c_status", rd, '0);
    check_eq("w1c_irq", W'(irq), '0);
    gpI2 = 32'd9;
    repeat (3) cycle(0, 5'h10, '0);
    check_eq("mask_status", rd, 32'h2);
    check_eq("mask_irq", W'(irq), '0);

    // Mid-operation reset
    cycle(1, 5'h08, '1);
    cycle(1, 5'h14, 32'h3);
    gpI1 = 32'd4;
    repeat (3) cycle(0, 5'h10, '0);
    check_eq("pre_rst_status", rd, 32'h3);
    check_eq("pre_rst_irq", W'(irq), 32'h1);
    check_eq("pre_rst_gpO1", gpO1, '1);
    cycle(0, 5'h18, '0);
    check_eq("unmapped_18", rd, '0);
    do_reset(2);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      automatic logic [4:0]   ad = 5'($urandom);
      automatic logic         w = ($urandom_range(0, 9) < 3);
      automatic logic [W-1:0] d = $urandom;
      if ($urandom_range(0, 3) == 0) d = exp_rd(ad);
      cycle(w, ad, d);
      if ($urandom_range(0, 7) == 0)
        gpI1 = $urandom_range(0, 1) ? $urandom : gpI1 ^ (32'h1 << $urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0)
        gpI2 = $urandom_range(0, 1) ? $urandom : gpI2 ^ (32'h1 << $urandom_range(0, 31));
      if ($urandom_range(0, 299) == 0) do_reset($urandom_range(1, 2));
    end
    cycle(0, 5'h10, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
